// File: rtl/xbar_cfg_pkg.sv
// Shared types and sizing for the LUT-tile input crossbar and its config path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xbar_cfg_pkg;

  localparam int NUM_IN  = 24;  // legal select values are 0..NUM_IN-1
  localparam int NUM_OUT = 28;  // one select field per crossbar output
  localparam int SEL_W   = 5;
  localparam int IDX_W   = 5;   // must cover NUM_OUT

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    ABORT
  } cfg_state_t;

endpackage

// File: rtl/xbar_cfg_loader.sv
// Crossbar config loader: collects select writes in a shadow, commits atomically.
// Latency: last beat accepted in cycle N -> new config live and commit pulse in N+2.
// Backpressure: io_cfg_ready drops for the single COMMIT/ABORT cycle after each set.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   io_cfg_*        valid/ready write beats {idx, sel, last}
//   io_mux_configs  live selects, field k = bits [k*SEL_W +: SEL_W]
//   io_commit_done  1-cycle pulse, new config live
//   io_cfg_err      1-cycle pulse, set aborted, live config unchanged
//   io_busy         high whenever the FSM is outside IDLE
module xbar_cfg_loader
  import xbar_cfg_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_cfg_valid,
  output logic                     io_cfg_ready,
  input  logic [IDX_W-1:0]         io_cfg_idx,
  input  logic [SEL_W-1:0]         io_cfg_sel,
  input  logic                     io_cfg_last,
  output logic [NUM_OUT*SEL_W-1:0] io_mux_configs,
  output logic                     io_commit_done,
  output logic                     io_cfg_err,
  output logic                     io_busy
);

  cfg_state_t state_q, state_d;
  sel_t       shadow_q [NUM_OUT];
  sel_t       shadow_d [NUM_OUT];
  sel_t       active_q [NUM_OUT];
  sel_t       active_d [NUM_OUT];
  logic       err_sticky_q, err_sticky_d;
  logic       commit_done_q, commit_done_d;
  logic       cfg_err_q, cfg_err_d;

  logic       beat_acc;
  logic       idx_ok;
  logic       sel_ok;
  logic       beat_ok;

  // Zero-extend both sides so the range check stays correct even if a
  // bound equals 2**width.
  assign idx_ok  = ({1'b0, io_cfg_idx} < (IDX_W+1)'(NUM_OUT));
  assign sel_ok  = ({1'b0, io_cfg_sel} < (SEL_W+1)'(NUM_IN));
  assign beat_ok = idx_ok & sel_ok;

  assign io_cfg_ready   = (state_q == IDLE) || (state_q == LOAD);
  assign beat_acc       = io_cfg_valid & io_cfg_ready;
  assign io_busy        = (state_q != IDLE);
  assign io_commit_done = commit_done_q;
  assign io_cfg_err     = cfg_err_q;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    err_sticky_d  = err_sticky_q;
    commit_done_d = 1'b0;
    cfg_err_d     = 1'b0;

    unique case (state_q)
      IDLE, LOAD: begin
        if (beat_acc) begin
          if (beat_ok) begin
            shadow_d[io_cfg_idx] = io_cfg_sel;
          end else begin
            err_sticky_d = 1'b1;
          end
          if (io_cfg_last) begin
            // The last beat's own legality counts as well as earlier beats'.
            state_d = (!err_sticky_q && beat_ok) ? COMMIT : ABORT;
          end else begin
            state_d = LOAD;
          end
        end
      end
      COMMIT: begin
        active_d      = shadow_q;
        commit_done_d = 1'b1;
        state_d       = IDLE;
      end
      ABORT: begin
        // Throw away the partial set so the shadow again mirrors the live
        // config; unwritten fields of the next set then keep their values.
        shadow_d     = active_q;
        err_sticky_d = 1'b0;
        cfg_err_d    = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      err_sticky_q  <= 1'b0;
      commit_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      err_sticky_q  <= err_sticky_d;
      commit_done_q <= commit_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  // Live bus comes straight from the active register.
  always_comb begin
    io_mux_configs = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      io_mux_configs[k*SEL_W +: SEL_W] = active_q[k];
    end
  end

endmodule

// File: tb/tb_xbar_cfg_loader.sv
module tb_xbar_cfg_loader;

  localparam int NO = 28;
  localparam int NI = 24;
  localparam int W  = NO * 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         drv_valid;
  logic         io_cfg_ready;
  logic [4:0]   drv_idx;
  logic [4:0]   drv_sel;
  logic         drv_last;
  logic         drv_kind;   // bench intent for a last beat: 1 commit, 0 abort
  logic [W-1:0] io_mux_configs;
  logic         io_commit_done;
  logic         io_cfg_err;
  logic         io_busy;

  xbar_cfg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .io_cfg_valid   (drv_valid),
    .io_cfg_ready   (io_cfg_ready),
    .io_cfg_idx     (drv_idx),
    .io_cfg_sel     (drv_sel),
    .io_cfg_last    (drv_last),
    .io_mux_configs (io_mux_configs),
    .io_commit_done (io_commit_done),
    .io_cfg_err     (io_cfg_err),
    .io_busy        (io_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] idx;
    logic [4:0] sel;
    logic       last;
    logic       kind;
  } vec_t;

  typedef struct {
    logic         kind;
    logic [W-1:0] cfg;
    int           cyc;
  } exp_t;

  int total = 0;
  int bad   = 0;

  exp_t         sb [$];
  vec_t         tbl [$];
  logic [4:0]   m_sh  [NO];
  logic [4:0]   m_act [NO];
  int           ms;        // 0 idle, 1 load, 2 commit/abort
  logic [W-1:0] live_exp;
  logic         chk_en = 1'b0;
  int           ncyc = 0;

  function automatic logic [W-1:0] pack(input logic [4:0] a [NO]);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NO; k++) r[k*5 +: 5] = a[k];
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (chk_en) begin
      if (io_commit_done || io_cfg_err) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: done=%b err=%b with nothing pending", io_commit_done, io_cfg_err);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", W'({io_commit_done, io_cfg_err}), W'(e.kind ? 2'b10 : 2'b01));
          chk("pulse_latency", W'(ncyc - e.cyc), W'(2));
          live_exp = e.cfg;
        end
      end
      chk("mux_configs", io_mux_configs, live_exp);
      chk("busy", W'(io_busy), W'(ms != 0));
      chk("ready", W'(io_cfg_ready), W'(ms < 2));
    end

    if (reset) begin
      ms = 0;
      for (int k = 0; k < NO; k++) begin
        m_sh[k]  = '0;
        m_act[k] = '0;
      end
      live_exp = '0;
      sb.delete();
    end else if (ms == 2) begin
      ms = 0;
    end else if (drv_valid) begin
      if (drv_idx < NO && drv_sel < NI) m_sh[drv_idx] = drv_sel;
      if (drv_last) begin
        if (drv_kind) begin
          for (int k = 0; k < NO; k++) m_act[k] = m_sh[k];
        end else begin
          for (int k = 0; k < NO; k++) m_sh[k] = m_act[k];
        end
        e.kind = drv_kind;
        e.cfg  = pack(m_act);
        e.cyc  = ncyc;
        sb.push_back(e);
        ms = 2;
      end else begin
        ms = 1;
      end
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [4:0] idx, input logic [4:0] sel,
                           input logic last, input logic kind);
    logic got;
    drv_valid = 1'b1;
    drv_idx   = idx;
    drv_sel   = sel;
    drv_last  = last;
    drv_kind  = kind;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (io_cfg_ready) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: ready=%b want 1 within 20 cycles", io_cfg_ready);
    end
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
  endtask

  function automatic void add(input int idx, input int sel, input bit last, input bit kind);
    vec_t v;
    v.idx  = 5'(idx);
    v.sel  = 5'(sel);
    v.last = last;
    v.kind = kind;
    tbl.push_back(v);
  endfunction

  initial begin
    reset     = 1'b1;
    drv_valid = 1'b0;
    drv_idx   = '0;
    drv_sel   = '0;
    drv_last  = 1'b0;
    drv_kind  = 1'b0;
    live_exp  = '0;
    ms        = 0;

    // Full set, sel = idx % 24, committed on idx 27.
    for (int i = 0; i < NO; i++) add(i, i % NI, i == NO - 1, 1'b1);
    // Same index twice: the later write wins.
    add(3, 23, 0, 0);
    add(3, 7, 1, 1);
    // Illegal select earlier in the set aborts the set; then a good retry.
    add(2, 24, 0, 0);
    add(5, 1, 1, 0);
    add(5, 1, 1, 1);
    // Illegal index on a lone last beat aborts.
    add(28, 0, 1, 0);
    // Largest legal select from IDLE; nothing else may have moved.
    add(0, 23, 1, 1);
    // Illegal index mid-set, then an otherwise legal last beat.
    add(31, 3, 0, 0);
    add(1, 2, 1, 0);
    // Illegal select on the last beat itself.
    add(6, 31, 1, 0);
    // Largest legal index.
    add(27, 9, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Quiet period after reset: checked every cycle by the monitor.
    repeat (5) @(posedge clk);
    #1;

    foreach (tbl[i]) send_beat(tbl[i].idx, tbl[i].sel, tbl[i].last, tbl[i].kind);

    // Valid held through COMMIT: the next set is only taken two cycles later.
    send_beat(5'd10, 5'd4, 1'b0, 1'b0);
    send_beat(5'd11, 5'd5, 1'b1, 1'b1);
    send_beat(5'd12, 5'd6, 1'b1, 1'b1);

    // Reset during COMMIT wins: no pulse, config cleared, held beat taken after.
    send_beat(5'd13, 5'd8, 1'b1, 1'b1);
    reset     = 1'b1;
    drv_valid = 1'b1;
    drv_idx   = 5'd4;
    drv_sel   = 5'd4;
    drv_last  = 1'b1;
    drv_kind  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_beat(5'd4, 5'd4, 1'b1, 1'b1);

    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_drained", W'(sb.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
